// File: rtl/dtw_score_tracker_pkg.sv
// ============================================================================
// Module   : dtw_score_tracker_pkg
// Purpose  : Shared constants and FSM encoding for the DTW score tracker slice
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dtw_score_tracker_pkg;

    localparam int c_dtw_word_len = 16;
    localparam int c_dtw_idx_len  = 16;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_RUN  = c_st_run,
        ST_DONE = c_st_done
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dtw_min_sel.sv
// ============================================================================
// Module   : dtw_min_sel
// Purpose  : Combinational running-minimum selector; ties keep the earlier index
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtw_min_sel
    import dtw_score_tracker_pkg::*;
#(
    parameter int WORD_LEN = c_dtw_word_len,
    parameter int IDX_LEN  = c_dtw_idx_len
) (
    input  logic [WORD_LEN-1:0] i_cur_min,
    input  logic [IDX_LEN-1:0]  i_cur_idx,
    input  logic [WORD_LEN-1:0] i_score,
    input  logic [IDX_LEN-1:0]  i_idx,
    output logic [WORD_LEN-1:0] o_new_min,
    output logic [IDX_LEN-1:0]  o_new_idx
);

    logic w_take;

    // Strict compare so an equal later score never displaces the first one
    assign w_take    = (i_score < i_cur_min);
    assign o_new_min = w_take ? i_score : i_cur_min;
    assign o_new_idx = w_take ? i_idx   : i_cur_idx;

endmodule

`default_nettype wire

// File: rtl/dtw_score_tracker.sv
// ============================================================================
// Module   : dtw_score_tracker
// Purpose  : Tracks min score/index of the last PE row and reports it via handshake
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtw_score_tracker
    import dtw_score_tracker_pkg::*;
#(
    parameter int WORD_LEN = c_dtw_word_len,
    parameter int IDX_LEN  = c_dtw_idx_len
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IDX_LEN-1:0]  ref_len,
    input  logic [WORD_LEN-1:0] threshold,
    input  logic                score_valid,
    input  logic [WORD_LEN-1:0] score,
    output logic                busy,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [WORD_LEN-1:0] min_score,
    output logic [IDX_LEN-1:0]  min_idx,
    output logic                hit
);

    localparam logic [WORD_LEN-1:0] c_inf     = '1;
    localparam logic [IDX_LEN-1:0]  c_idx_one = {{(IDX_LEN-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_LEN-1:0]  r_ref_len;
    logic [IDX_LEN-1:0]  r_idx;
    logic [IDX_LEN-1:0]  r_min_idx;
    logic [WORD_LEN-1:0] r_threshold;
    logic [WORD_LEN-1:0] r_min_score;
    logic                r_hit;

    logic [WORD_LEN-1:0] w_sel_min;
    logic [IDX_LEN-1:0]  w_sel_idx;
    logic                w_start_ok;
    logic                w_zero_len;
    logic                w_accept;
    logic                w_last;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_zero_len = (ref_len == '0);
    assign w_accept   = (r_state == ST_RUN) && score_valid;
    // r_ref_len is never zero in RUN, so the decrement cannot underflow here
    assign w_last     = w_accept && (r_idx == (r_ref_len - c_idx_one));

    dtw_min_sel #(
        .WORD_LEN (WORD_LEN),
        .IDX_LEN  (IDX_LEN)
    ) u_min_sel (
        .i_cur_min (r_min_score),
        .i_cur_idx (r_min_idx),
        .i_score   (score),
        .i_idx     (r_idx),
        .o_new_min (w_sel_min),
        .o_new_idx (w_sel_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_len ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_len   <= '0;
            r_threshold <= '0;
            r_idx       <= '0;
            r_min_score <= c_inf;
            r_min_idx   <= '0;
            r_hit       <= 1'b0;
        end else if (w_start_ok) begin
            r_ref_len   <= ref_len;
            r_threshold <= threshold;
            r_idx       <= '0;
            r_min_score <= c_inf;
            r_min_idx   <= '0;
            // An empty pass finishes immediately with an INF result
            r_hit       <= w_zero_len && (c_inf <= threshold);
        end else if (w_accept) begin
            r_min_score <= w_sel_min;
            r_min_idx   <= w_sel_idx;
            r_idx       <= r_idx + c_idx_one;
            if (w_last) begin
                r_hit <= (w_sel_min <= r_threshold);
            end
        end
    end

    assign busy         = (r_state == ST_RUN);
    assign result_valid = (r_state == ST_DONE);
    assign min_score    = r_min_score;
    assign min_idx      = r_min_idx;
    assign hit          = r_hit;

endmodule

`default_nettype wire

// File: tb/tb_dtw_score_tracker.sv
// ============================================================================
// Module   : tb_dtw_score_tracker
// Purpose  : Self-checking bench for dtw_score_tracker with a queue-based model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dtw_score_tracker;

    localparam int WL = 16;
    localparam int IL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IL-1:0] ref_len;
    logic [WL-1:0] threshold;
    logic          score_valid;
    logic [WL-1:0] score;
    logic          busy;
    logic          result_valid;
    logic          result_ready;
    logic [WL-1:0] min_score;
    logic [IL-1:0] min_idx;
    logic          hit;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observed tuple: {result_valid, busy, min_score, min_idx, hit}
    logic [WL+IL+2:0] obs;
    logic [WL+IL+2:0] exp_t;
    assign obs = {result_valid, busy, min_score, min_idx, hit};

    always #5 clk = ~clk;

    dtw_score_tracker #(.WORD_LEN(WL), .IDX_LEN(IL)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ref_len      (ref_len),
        .threshold    (threshold),
        .score_valid  (score_valid),
        .score        (score),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .min_score    (min_score),
        .min_idx      (min_idx),
        .hit          (hit)
    );

    // One clock of stimulus; returns 1ns after the edge that consumed it
    task automatic cyc(input logic sv, input logic [WL-1:0] s, input logic st, input logic rr);
        score_valid  = sv;
        score        = s;
        start        = st;
        result_ready = rr;
        @(posedge clk);
        #1;
        score_valid  = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
    endtask

    task automatic begin_pass(input logic [IL-1:0] len, input logic [WL-1:0] thr);
        ref_len   = len;
        threshold = thr;
        cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Reference: overall minimum, then the first position holding it
    function automatic logic [WL+IL:0] model(input logic [WL-1:0] q[$], input logic [WL-1:0] thr);
        logic [WL-1:0] m;
        logic [IL-1:0] mi;
        bit            found;
        m     = '1;
        mi    = '0;
        found = 0;
        foreach (q[i]) if (q[i] < m) m = q[i];
        foreach (q[i]) begin
            if (!found && q[i] == m) begin
                mi    = IL'(i);
                found = 1;
            end
        end
        return {m, mi, (m <= thr)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; score_valid = 1'b0; result_ready = 1'b0;
        ref_len = '0; threshold = '0; score = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_t = {1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", obs, exp_t);
        end
    endtask

    task automatic test_basic();
        begin_pass(16'd4, 16'd10);
        n_cmp++;
        if ({busy, result_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_busy got=%b want=10", {busy, result_valid});
        end
        cyc(1'b1, 16'd30, 1'b0, 1'b0);
        cyc(1'b1, 16'd7,  1'b0, 1'b0);
        cyc(1'b1, 16'd12, 1'b0, 1'b0);
        n_cmp++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid got=%b want=0", result_valid);
        end
        cyc(1'b1, 16'd7, 1'b0, 1'b0);
        exp_t = {1'b1, 1'b0, 16'd7, 16'd1, 1'b1};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL basic_result got=%h want=%h", obs, exp_t);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        exp_t = {1'b0, 1'b0, 16'd7, 16'd1, 1'b1};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL basic_idle_hold got=%h want=%h", obs, exp_t);
        end
    endtask

    task automatic test_gapped_backpressure();
        begin_pass(16'd3, 16'd5);
        cyc(1'b1, 16'd9, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 1'b0, 1'b0);
        n_cmp++;
        if ({busy, result_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL gap_hold got=%b want=10", {busy, result_valid});
        end
        cyc(1'b1, 16'd8, 1'b0, 1'b0);
        cyc(1'b1, 16'd6, 1'b0, 1'b0);
        exp_t = {1'b1, 1'b0, 16'd6, 16'd2, 1'b0};
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== exp_t) begin
                n_fail++;
                $display("FAIL gap_wait%0d got=%h want=%h", i, obs, exp_t);
            end
            cyc(1'b0, '0, 1'b0, 1'b0);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        exp_t = {1'b0, 1'b0, 16'd6, 16'd2, 1'b0};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL gap_release got=%h want=%h", obs, exp_t);
        end
    endtask

    task automatic test_inf();
        logic [WL-1:0] thr_tab [2];
        thr_tab[0] = 16'hFFFE;
        thr_tab[1] = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            begin_pass(16'd2, thr_tab[k]);
            cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
            cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
            exp_t = {1'b1, 1'b0, 16'hFFFF, 16'h0000, (k == 1)};
            n_cmp++;
            if (obs !== exp_t) begin
                n_fail++;
                $display("FAIL inf_thr%0d got=%h want=%h", k, obs, exp_t);
            end
            cyc(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_zero_len();
        logic [WL-1:0] thr_tab [2];
        thr_tab[0] = 16'hFFFF;
        thr_tab[1] = 16'h1234;
        for (int k = 0; k < 2; k++) begin
            begin_pass(16'd0, thr_tab[k]);
            exp_t = {1'b1, 1'b0, 16'hFFFF, 16'h0000, (k == 0)};
            n_cmp++;
            if (obs !== exp_t) begin
                n_fail++;
                $display("FAIL zero_len%0d got=%h want=%h", k, obs, exp_t);
            end
            cyc(1'b0, '0, 1'b0, 1'b1);
            n_cmp++;
            if ({busy, result_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL zero_len_idle%0d got=%b want=00", k, {busy, result_valid});
            end
        end
    endtask

    task automatic test_ignored();
        cyc(1'b1, 16'd0, 1'b0, 1'b1);
        exp_t = {1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL ign_idle_score got=%h want=%h", obs, exp_t);
        end
        begin_pass(16'd2, 16'd3);
        ref_len = 16'd9;
        cyc(1'b0, 16'd0, 1'b1, 1'b0);
        cyc(1'b1, 16'd4, 1'b1, 1'b0);
        n_cmp++;
        if ({busy, result_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL ign_run_start got=%b want=10", {busy, result_valid});
        end
        cyc(1'b1, 16'd3, 1'b1, 1'b0);
        exp_t = {1'b1, 1'b0, 16'd3, 16'd1, 1'b1};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL ign_result got=%h want=%h", obs, exp_t);
        end
        cyc(1'b1, 16'd0, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL ign_done_score got=%h want=%h", obs, exp_t);
        end
        cyc(1'b0, 16'd0, 1'b1, 1'b1);
        cyc(1'b0, 16'd0, 1'b0, 1'b0);
        exp_t = {1'b0, 1'b0, 16'd3, 16'd1, 1'b1};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL ign_handshake_start got=%h want=%h", obs, exp_t);
        end
    endtask

    task automatic test_reset_mid_pass();
        begin_pass(16'd5, 16'd100);
        cyc(1'b1, 16'd50, 1'b0, 1'b0);
        cyc(1'b1, 16'd20, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_t = {1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL rst_mid got=%h want=%h", obs, exp_t);
        end
        begin_pass(16'd3, 16'd40);
        cyc(1'b1, 16'd45, 1'b0, 1'b0);
        cyc(1'b1, 16'd41, 1'b0, 1'b0);
        cyc(1'b1, 16'd44, 1'b0, 1'b0);
        exp_t = {1'b1, 1'b0, 16'd41, 16'd1, 1'b0};
        n_cmp++;
        if (obs !== exp_t) begin
            n_fail++;
            $display("FAIL rst_new_pass got=%h want=%h", obs, exp_t);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [WL-1:0] q[$];
        logic [WL-1:0] thr;
        logic [WL-1:0] s;
        logic [WL+IL:0] m;
        int             len;
        for (int p = 0; p < 30; p++) begin
            len = int'($urandom_range(0, 10));
            thr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : WL'($urandom_range(0, 16));
            q.delete();
            begin_pass(IL'(len), thr);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) cyc(1'b0, WL'($urandom), 1'(($urandom_range(0, 1))), 1'b0);
                case ($urandom_range(0, 3))
                    0:       s = 16'hFFFF;
                    1:       s = WL'($urandom);
                    default: s = WL'($urandom_range(0, 15));
                endcase
                q.push_back(s);
                n_cmp++;
                if (result_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_early_valid i=%0d got=%b want=0", p, i, result_valid);
                end
                cyc(1'b1, s, 1'b0, 1'b0);
            end
            m = model(q, thr);
            exp_t = {1'b1, 1'b0, m};
            repeat ($urandom_range(1, 3)) begin
                n_cmp++;
                if (obs !== exp_t) begin
                    n_fail++;
                    $display("FAIL rnd%0d_result len=%0d got=%h want=%h", p, len, obs, exp_t);
                end
                cyc(1'b1, WL'($urandom), 1'b1, 1'b0);
            end
            cyc(1'b0, '0, 1'b0, 1'b1);
            n_cmp++;
            if ({busy, result_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL rnd%0d_release got=%b want=00", p, {busy, result_valid});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gapped_backpressure();
        test_inf();
        test_zero_len();
        test_ignored();
        test_reset_mid_pass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
